mux_4x1_rr_stream: RTL and testbench

Four-channel to one-channel stream multiplexer with round-robin arbitration and a registered output stage. It is the collecting counterpart of the 1x4 demultiplexer path. It merges four valid/ready producer channels into one consumer stream. Each output beat is tagged with its 2-bit source index so a downstream 1x4 demux can route it back out. The block sustains one beat per cycle with a fixed latency of 1 cycle.

---
 rtl/mux_4x1_rr_stream_pkg.sv | 33 +++
 rtl/mux_2x1_w.sv | 13 +
 rtl/mux_4x1_rr_stream.sv | 79 +++++++
 tb/tb_mux_4x1_rr_stream.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mux_4x1_rr_stream_pkg.sv
// Shared types and constants for the 4:1 round-robin stream mux.
// Holds the grant search used by the top-level arbiter.
package mux_4x1_rr_stream_pkg;

    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t PTR_RST = 2'd3;

    typedef struct packed {
        logic any;
        sel_t g;
    } grant_t;

    // Walk offsets from farthest to nearest so the nearest requester after ptr wins.
    function automatic grant_t rr_search(input sel_t ptr, input logic [N_CH-1:0] req);
        grant_t r;
        sel_t   idx;
        r.any = 1'b0;
        r.g   = ptr;
        for (int i = N_CH; i >= 1; i--) begin
            idx = ptr + sel_t'(i);
            if (req[idx]) begin
                r.any = 1'b1;
                r.g   = idx;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_2x1_w.sv
// W-bit 2:1 select leaf for the data-select tree; purely combinational, 0 cycles.
module mux_2x1_w #(
    parameter int W = 8
) (
    input  logic         sel,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y
);

    assign y = sel ? b : a;

endmodule

// File: rtl/mux_4x1_rr_stream.sv
// 4:1 valid/ready stream merge with round-robin grant and a registered output; latency 1 cycle.
// Backpressure: a stalled full output register drops every i_ready in the same cycle.
module mux_4x1_rr_stream
    import mux_4x1_rr_stream_pkg::*;
#(
    parameter int W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_CH-1:0]   i_valid,
    input  logic [N_CH*W-1:0] i_data,
    output logic [N_CH-1:0]   i_ready,
    output logic              y_valid,
    output logic [W-1:0]      y_data,
    output logic [SEL_W-1:0]  y_sel,
    input  logic              y_ready
);

    logic         load;
    grant_t       gnt;
    sel_t         ptr;
    logic [W-1:0] lo_dat;
    logic [W-1:0] hi_dat;
    logic [W-1:0] sel_dat;

    assign load = ~y_valid | y_ready;

    always_comb begin
        gnt = rr_search(ptr, i_valid);
    end

    // Ready is forced low during reset so no producer believes a beat was taken.
    always_comb begin
        i_ready = '0;
        if (rst_n && load && gnt.any) begin
            i_ready[gnt.g] = 1'b1;
        end
    end

    mux_2x1_w #(.W(W)) u_mux_lo (
        .sel (gnt.g[0]),
        .a   (i_data[0*W +: W]),
        .b   (i_data[1*W +: W]),
        .y   (lo_dat)
    );

    mux_2x1_w #(.W(W)) u_mux_hi (
        .sel (gnt.g[0]),
        .a   (i_data[2*W +: W]),
        .b   (i_data[3*W +: W]),
        .y   (hi_dat)
    );

    mux_2x1_w #(.W(W)) u_mux_out (
        .sel (gnt.g[1]),
        .a   (lo_dat),
        .b   (hi_dat),
        .y   (sel_dat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_valid <= 1'b0;
            y_data  <= '0;
            y_sel   <= '0;
            ptr     <= PTR_RST;
        end else if (load) begin
            if (gnt.any) begin
                y_valid <= 1'b1;
                y_data  <= sel_dat;
                y_sel   <= gnt.g;
                ptr     <= gnt.g;
            end else begin
                y_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_4x1_rr_stream.sv
// Self-checking bench for mux_4x1_rr_stream: directed scenarios plus randomized producers.
module tb_mux_4x1_rr_stream;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [3:0]     i_valid;
    logic [4*W-1:0] i_data;
    logic [3:0]     i_ready;
    logic           y_valid;
    logic [W-1:0]   y_data;
    logic [1:0]     y_sel;
    logic           y_ready;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic         m_valid;
    logic [W-1:0] m_data;
    int           m_sel;
    int           m_ptr;
    int           xfer_ch;

    mux_4x1_rr_stream #(.W(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_data  (i_data),
        .i_ready (i_ready),
        .y_valid (y_valid),
        .y_data  (y_data),
        .y_sel   (y_sel),
        .y_ready (y_ready)
    );

    always #5 clk = ~clk;

    // Nearest valid channel strictly after p going round the ring; p itself is last.
    function automatic int pick(input logic [3:0] v, input int p);
        int best = -1;
        int bd   = 5;
        for (int k = 0; k < 4; k++) begin
            if (v[k]) begin
                int d = (k - p + 4) % 4;
                if (d == 0) d = 4;
                if (d < bd) begin
                    bd   = d;
                    best = k;
                end
            end
        end
        return best;
    endfunction

    function automatic logic [3:0] exp_ready();
        int g;
        if (!rst_n) return 4'b0000;
        g = pick(i_valid, m_ptr);
        if ((!m_valid || y_ready) && g >= 0) return 4'b0001 << g;
        return 4'b0000;
    endfunction

    task automatic tick();
        int g;
        @(posedge clk);
        xfer_ch = -1;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_data  = '0;
            m_sel   = 0;
            m_ptr   = 3;
        end else if (!m_valid || y_ready) begin
            g = pick(i_valid, m_ptr);
            if (g >= 0) begin
                xfer_ch = g;
                m_valid = 1'b1;
                m_data  = i_data[g*W +: W];
                m_sel   = g;
                m_ptr   = g;
            end else begin
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        i_valid = 4'b1111;
        i_data  = 32'h13121110;
        y_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (i_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready cyc=%0d got=%b exp=0000", c, i_ready); end
            tick();
            checks++; if (y_valid !== 1'b0) begin failures++; $display("FAIL reset_yvalid cyc=%0d got=%b exp=0", c, y_valid); end
            checks++; if (y_data !== 8'h00 || y_sel !== 2'd0) begin failures++; $display("FAIL reset_regs cyc=%0d data=%h sel=%0d exp 00/0", c, y_data, y_sel); end
        end
        rst_n = 1'b1;
        #1;
        checks++; if (i_ready !== 4'b0001) begin failures++; $display("FAIL first_grant_ready got=%b exp=0001", i_ready); end
        tick();
        checks++; if (y_valid !== 1'b1 || y_sel !== 2'd0 || y_data !== 8'h10) begin failures++; $display("FAIL first_grant v=%b sel=%0d data=%h exp 1/0/10", y_valid, y_sel, y_data); end
    endtask

    task automatic test_round_robin();
        i_valid = 4'b1111;
        i_data  = 32'h13121110;
        y_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            #1;
            checks++; if (i_ready !== exp_ready()) begin failures++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", c, i_ready, exp_ready()); end
            tick();
            checks++; if (y_valid !== 1'b1 || y_sel !== 2'((c + 1) % 4) || y_data !== 8'(8'h10 + (c + 1) % 4)) begin
                failures++; $display("FAIL rr_beat cyc=%0d v=%b sel=%0d data=%h exp sel=%0d", c, y_valid, y_sel, y_data, (c + 1) % 4);
            end
        end
    endtask

    task automatic test_single_channel();
        i_valid = 4'b0100;
        i_data  = 32'h00A50000;
        y_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (i_ready !== 4'b0100) begin failures++; $display("FAIL single_ready cyc=%0d got=%b exp=0100", c, i_ready); end
            tick();
            checks++; if (y_valid !== 1'b1 || y_sel !== 2'd2 || y_data !== 8'hA5) begin failures++; $display("FAIL single_beat cyc=%0d v=%b sel=%0d data=%h exp 1/2/a5", c, y_valid, y_sel, y_data); end
        end
    endtask

    task automatic test_backpressure();
        y_ready = 1'b1;
        i_valid = 4'b0010;
        i_data  = 32'h00001100;
        #1;
        tick();
        checks++; if (y_data !== 8'h11 || y_sel !== 2'd1) begin failures++; $display("FAIL bp_setup data=%h sel=%0d exp 11/1", y_data, y_sel); end
        y_ready = 1'b0;
        i_valid = 4'b1010;
        i_data  = 32'h33002100;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (i_ready !== 4'b0000) begin failures++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", c, i_ready); end
            tick();
            checks++; if (y_valid !== 1'b1 || y_data !== 8'h11 || y_sel !== 2'd1) begin failures++; $display("FAIL bp_hold cyc=%0d v=%b data=%h sel=%0d exp 1/11/1", c, y_valid, y_data, y_sel); end
        end
        y_ready = 1'b1;
        #1;
        checks++; if (i_ready !== 4'b1000) begin failures++; $display("FAIL bp_release_ready got=%b exp=1000", i_ready); end
        tick();
        checks++; if (y_sel !== 2'd3 || y_data !== 8'h33) begin failures++; $display("FAIL bp_release sel=%0d data=%h exp 3/33", y_sel, y_data); end
    endtask

    task automatic test_wrap();
        i_valid = 4'b1001;
        i_data  = 32'h43000040;
        y_ready = 1'b1;
        #1;
        checks++; if (i_ready !== 4'b0001) begin failures++; $display("FAIL wrap_ready0 got=%b exp=0001", i_ready); end
        tick();
        checks++; if (y_sel !== 2'd0 || y_data !== 8'h40) begin failures++; $display("FAIL wrap_beat0 sel=%0d data=%h exp 0/40", y_sel, y_data); end
        i_data = 32'h43000050;
        #1;
        checks++; if (i_ready !== 4'b1000) begin failures++; $display("FAIL wrap_ready3 got=%b exp=1000", i_ready); end
        tick();
        checks++; if (y_sel !== 2'd3 || y_data !== 8'h43) begin failures++; $display("FAIL wrap_beat3 sel=%0d data=%h exp 3/43", y_sel, y_data); end
    endtask

    task automatic test_mid_reset();
        y_ready = 1'b1;
        i_valid = 4'b0010;
        i_data  = 32'h00006600;
        #1;
        tick();
        y_ready = 1'b0;
        #1;
        tick();
        checks++; if (y_valid !== 1'b1 || y_data !== 8'h66) begin failures++; $display("FAIL midrst_stall v=%b data=%h exp 1/66", y_valid, y_data); end
        rst_n = 1'b0;
        #1;
        tick();
        checks++; if (y_valid !== 1'b0 || y_data !== 8'h00 || y_sel !== 2'd0) begin failures++; $display("FAIL midrst_regs v=%b data=%h sel=%0d exp 0/00/0", y_valid, y_data, y_sel); end
        rst_n   = 1'b1;
        i_valid = 4'b1111;
        i_data  = 32'h13121110;
        #1;
        checks++; if (i_ready !== 4'b0001) begin failures++; $display("FAIL midrst_regrant got=%b exp=0001", i_ready); end
        tick();
        checks++; if (y_sel !== 2'd0 || y_data !== 8'h10) begin failures++; $display("FAIL midrst_beat sel=%0d data=%h exp 0/10", y_sel, y_data); end
    endtask

    task automatic test_random();
        logic [3:0] pv = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 4; k++) begin
                if (!pv[k] && $urandom_range(1, 0) == 1) begin
                    pv[k] = 1'b1;
                    i_data[k*W +: W] = 8'($urandom);
                end
            end
            i_valid = pv;
            y_ready = ($urandom_range(3, 0) != 0);
            #1;
            checks++; if (i_ready !== exp_ready()) begin failures++; $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, i_ready, exp_ready()); end
            tick();
            if (xfer_ch >= 0) pv[xfer_ch] = 1'b0;
            checks++; if (y_valid !== m_valid || y_data !== m_data || y_sel !== 2'(m_sel)) begin
                failures++; $display("FAIL rand_out cyc=%0d v=%b data=%h sel=%0d exp %b/%h/%0d", c, y_valid, y_data, y_sel, m_valid, m_data, m_sel);
            end
        end
    endtask

    initial begin
        m_valid = 1'b0;
        m_data  = '0;
        m_sel   = 0;
        m_ptr   = 3;
        xfer_ch = -1;
        rst_n   = 1'b0;
        i_valid = '0;
        i_data  = '0;
        y_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_single_channel();
        test_backpressure();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
